// File: rtl/store_buffer.sv
// store_buffer: in-order store queue in front of a single-ported DataMem.
// Stores are queued in one cycle and retired in program order on cycles when
// the port is otherwise free. A load goes straight to DataMem unless its bytes
// overlap a queued store. In that case the stage stalls while the head drains.
// Optional feature macro: STBUF_FWD_EN. When it is defined, a load whose bytes
// are fully covered by the youngest overlapping entry is served from the queue.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic [7:0]    addr_i,
  input  logic [2:0]    func3_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o,
  output logic          stall_o,
  output logic [CW-1:0] count_o,
  output logic          dm_MemRead,
  output logic          dm_MemWrite,
  output logic [7:0]    dm_addr,
  output logic [2:0]    dm_func3,
  output logic [31:0]   dm_data_in,
  input  logic [31:0]   dm_data_out
);

  localparam int PW = $clog2(DEPTH);

  // Queue storage; only the low two func3 bits (access size) are kept.
  logic [7:0]    addr_mem [DEPTH];
  logic [1:0]    size_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  logic          push;
  logic          pop;
  logic          full;
  logic          any_ovl;
  logic          fwd_hit;
  logic [31:0]   fwd_data;

  logic [8:0]    ld_lo;
  logic [8:0]    ld_hi;
  logic [8:0]    ent_lo  [DEPTH];
  logic [8:0]    ent_hi  [DEPTH];
  logic [PW-1:0] ent_age [DEPTH];
  logic [DEPTH-1:0] ent_ovl;

  // Last byte touched by an access; 9 bits so the range compare cannot wrap.
  function automatic logic [8:0] last_byte(input logic [7:0] a, input logic [1:0] sz);
    logic [8:0] span;
    case (sz)
      2'b00:   span = 9'd0;
      2'b01:   span = 9'd1;
      default: span = 9'd3;
    endcase
    return {1'b0, a} + span;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign count_o = count_reg;
  assign ld_lo   = {1'b0, addr_i};
  assign ld_hi   = last_byte(addr_i, func3_i[1:0]);
  assign any_ovl = |ent_ovl;

  // Per-entry byte range, age (0 = oldest) and overlap with the current load.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic ent_valid;
      assign ent_age[gi] = PW'(gi) - head_reg;
      assign ent_valid   = (CW'(ent_age[gi]) < count_reg);
      assign ent_lo[gi]  = {1'b0, addr_mem[gi]};
      assign ent_hi[gi]  = last_byte(addr_mem[gi], size_mem[gi]);
      assign ent_ovl[gi] = ent_valid && (ent_lo[gi] <= ld_hi) && (ld_lo <= ent_hi[gi]);
    end
  endgenerate

`ifdef STBUF_FWD_EN
  logic [PW-1:0] fwd_idx;
  logic [PW-1:0] fwd_age;
  logic          fwd_found;
  logic [1:0]    fwd_shift;
  logic [31:0]   fwd_word;

  // Pick the youngest overlapping entry; no younger entry can then overlap.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    fwd_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_ovl[i] && (!fwd_found || ent_age[i] > fwd_age)) begin
        fwd_found = 1'b1;
        fwd_age   = ent_age[i];
        fwd_idx   = PW'(i);
      end
    end
  end

  // Forward only on full containment; extract and extend the load bytes.
  always_comb begin
    fwd_shift = ld_lo[1:0] - ent_lo[fwd_idx][1:0];
    fwd_word  = data_mem[fwd_idx] >> {fwd_shift, 3'b000};
    case (func3_i)
      3'b000:  fwd_data = {{24{fwd_word[7]}}, fwd_word[7:0]};
      3'b001:  fwd_data = {{16{fwd_word[15]}}, fwd_word[15:0]};
      3'b100:  fwd_data = {24'h0, fwd_word[7:0]};
      3'b101:  fwd_data = {16'h0, fwd_word[15:0]};
      default: fwd_data = fwd_word;
    endcase
    fwd_hit = fwd_found && (ent_lo[fwd_idx] <= ld_lo) && (ld_hi <= ent_hi[fwd_idx]);
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 32'h0;
`endif

  // Per-cycle arbitration of the DataMem port and the stall decision.
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    stall_o     = 1'b0;
    rdata_o     = 32'h0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_addr     = 8'h0;
    dm_func3    = 3'h0;
    dm_data_in  = 32'h0;
    if (!rst) begin
      if (mem_read_i) begin
        if (!any_ovl) begin
          dm_MemRead = 1'b1;
          dm_addr    = addr_i;
          dm_func3   = func3_i;
          rdata_o    = dm_data_out;
        end else if (fwd_hit) begin
          rdata_o = fwd_data;
        end else begin
          stall_o = 1'b1;
          pop     = 1'b1;
        end
      end else if (mem_write_i) begin
        if (!full) begin
          push = 1'b1;
        end else begin
          stall_o = 1'b1;
          pop     = 1'b1;
        end
      end else if (count_reg != '0) begin
        pop = 1'b1;
      end
      if (pop) begin
        dm_MemWrite = 1'b1;
        dm_addr     = addr_mem[head_reg];
        dm_func3    = {1'b0, size_mem[head_reg]};
        dm_data_in  = data_mem[head_reg];
      end
    end
  end

  // Entry payload write at the tail; contents need no reset, count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= addr_i;
      size_mem[tail_reg] <= func3_i[1:0];
      data_mem[tail_reg] <= wdata_i;
    end
  end

  // Pointer and occupancy update; push and pop are never both active.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (push) begin
      tail_reg  <= tail_reg + PW'(1);
      count_reg <= count_reg + CW'(1);
    end else if (pop) begin
      head_reg  <= head_reg + PW'(1);
      count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scoreboard bench for store_buffer (DEPTH=4).
// Stimulus pushes the hand-computed expected outputs of each cycle; a monitor
// on the falling edge pops and compares them. DataMem is a byte-array model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [7:0]  addr_i = 8'h0;
  logic [2:0]  func3_i = 3'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic [2:0]  count_o;
  logic        dm_MemRead;
  logic        dm_MemWrite;
  logic [7:0]  dm_addr;
  logic [2:0]  dm_func3;
  logic [31:0] dm_data_in;
  logic [31:0] dm_data_out;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .func3_i(func3_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .stall_o(stall_o), .count_o(count_o), .dm_MemRead(dm_MemRead),
    .dm_MemWrite(dm_MemWrite), .dm_addr(dm_addr), .dm_func3(dm_func3),
    .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
  );

  always #5 clk = ~clk;

  // DataMem model: combinational extended read, byte-lane write on the edge.
  logic [7:0] mem [256];
  logic       mem_clear = 1'b1;
  logic [7:0] b0, b1, b2, b3;
  assign b0 = mem[dm_addr];
  assign b1 = mem[dm_addr + 8'd1];
  assign b2 = mem[dm_addr + 8'd2];
  assign b3 = mem[dm_addr + 8'd3];

  always_comb begin
    case (dm_func3)
      3'b000:  dm_data_out = {{24{b0[7]}}, b0};
      3'b001:  dm_data_out = {{16{b1[7]}}, b1, b0};
      3'b010:  dm_data_out = {b3, b2, b1, b0};
      3'b100:  dm_data_out = {24'h0, b0};
      3'b101:  dm_data_out = {16'h0, b1, b0};
      default: dm_data_out = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h14;
      mem[1] <= 8'h09;
      mem[2] <= 8'h04;
      mem[3] <= 8'h00;
    end else if (dm_MemWrite) begin
      mem[dm_addr] <= dm_data_in[7:0];
      if (dm_func3[1:0] != 2'b00) mem[dm_addr + 8'd1] <= dm_data_in[15:8];
      if (dm_func3[1]) begin
        mem[dm_addr + 8'd2] <= dm_data_in[23:16];
        mem[dm_addr + 8'd3] <= dm_data_in[31:24];
      end
    end
  end

  typedef struct packed {
    logic        stall;
    logic [31:0] rdata;
    logic        mr;
    logic        mw;
    logic [7:0]  da;
    logic [2:0]  df;
    logic [31:0] dd;
    logic [2:0]  cnt;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got 0x%08h expected 0x%08h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "stall", {31'h0, stall_o}, {31'h0, e.stall});
      cmp(nm, "rdata", rdata_o, e.rdata);
      cmp(nm, "dm_MemRead", {31'h0, dm_MemRead}, {31'h0, e.mr});
      cmp(nm, "dm_MemWrite", {31'h0, dm_MemWrite}, {31'h0, e.mw});
      cmp(nm, "dm_addr", {24'h0, dm_addr}, {24'h0, e.da});
      cmp(nm, "dm_func3", {29'h0, dm_func3}, {29'h0, e.df});
      cmp(nm, "dm_data_in", dm_data_in, e.dd);
      cmp(nm, "count", {29'h0, count_o}, {29'h0, e.cnt});
      $display("txn %-14s stall=%0b rdata=%08h rd=%0b wr=%0b addr=%02h f3=%03b din=%08h count=%0d",
               nm, stall_o, rdata_o, dm_MemRead, dm_MemWrite, dm_addr, dm_func3, dm_data_in, count_o);
    end
  end

  function automatic exp_t ex(input logic st, input logic [31:0] rv, input logic mr, input logic mw,
                              input logic [7:0] da, input logic [2:0] df, input logic [31:0] dd,
                              input logic [2:0] cnt);
    exp_t e;
    e.stall = st; e.rdata = rv; e.mr = mr; e.mw = mw;
    e.da = da; e.df = df; e.dd = dd; e.cnt = cnt;
    return e;
  endfunction

  task automatic step(input string nm, input logic rs, input logic rd, input logic wr,
                      input logic [7:0] a, input logic [2:0] f, input logic [31:0] wd, input exp_t e);
    @(posedge clk);
    #1;
    rst = rs; mem_read_i = rd; mem_write_i = wr;
    addr_i = a; func3_i = f; wdata_i = wd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic st(input string nm, input logic [7:0] a, input logic [2:0] f, input logic [31:0] wd, input logic [2:0] cnt);
    step(nm, 1'b0, 1'b0, 1'b1, a, f, wd, ex(1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 3'h0, 32'h0, cnt));
  endtask

  task automatic st_full(input string nm, input logic [7:0] a, input logic [2:0] f, input logic [31:0] wd,
                         input logic [2:0] cnt, input logic [7:0] da, input logic [2:0] df, input logic [31:0] dd);
    step(nm, 1'b0, 1'b0, 1'b1, a, f, wd, ex(1'b1, 32'h0, 1'b0, 1'b1, da, df, dd, cnt));
  endtask

  task automatic idle(input string nm, input logic [2:0] cnt);
    step(nm, 1'b0, 1'b0, 1'b0, 8'h0, 3'h0, 32'h0, ex(1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 3'h0, 32'h0, cnt));
  endtask

  task automatic rst_cyc(input string nm, input logic [2:0] cnt);
    step(nm, 1'b1, 1'b0, 1'b0, 8'h0, 3'h0, 32'h0, ex(1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 3'h0, 32'h0, cnt));
  endtask

  task automatic drain(input string nm, input logic [2:0] cnt, input logic [7:0] da, input logic [2:0] df, input logic [31:0] dd);
    step(nm, 1'b0, 1'b0, 1'b0, 8'h0, 3'h0, 32'h0, ex(1'b0, 32'h0, 1'b0, 1'b1, da, df, dd, cnt));
  endtask

  task automatic ld_mem(input string nm, input logic [7:0] a, input logic [2:0] f, input logic [2:0] cnt, input logic [31:0] rv);
    step(nm, 1'b0, 1'b1, 1'b0, a, f, 32'h0, ex(1'b0, rv, 1'b1, 1'b0, a, f, 32'h0, cnt));
  endtask

  task automatic ld_stall(input string nm, input logic [7:0] a, input logic [2:0] f, input logic [2:0] cnt,
                          input logic [7:0] da, input logic [2:0] df, input logic [31:0] dd);
    step(nm, 1'b0, 1'b1, 1'b0, a, f, 32'h0, ex(1'b1, 32'h0, 1'b0, 1'b1, da, df, dd, cnt));
  endtask

`ifdef STBUF_FWD_EN
  task automatic ld_fwd(input string nm, input logic [7:0] a, input logic [2:0] f, input logic [2:0] cnt, input logic [31:0] rv);
    step(nm, 1'b0, 1'b1, 1'b0, a, f, 32'h0, ex(1'b0, rv, 1'b0, 1'b0, 8'h0, 3'h0, 32'h0, cnt));
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_clear = 1'b0;

    // Reset discards a 3-entry queue and issues no writes.
    st("t1_sw0", 8'h80, 3'b010, 32'h1, 3'd0);
    st("t1_sw1", 8'h84, 3'b010, 32'h2, 3'd1);
    st("t1_sw2", 8'h88, 3'b010, 32'h3, 3'd2);
    rst_cyc("t1_rst", 3'd3);
    idle("t1_idle0", 3'd0);
    idle("t1_idle1", 3'd0);

    // Single store retires on the first idle cycle.
    st("t2_sw", 8'h10, 3'b010, 32'hDEADBEEF, 3'd0);
    drain("t2_drain", 3'd1, 8'h10, 3'b010, 32'hDEADBEEF);
    idle("t2_idle", 3'd0);
    ld_mem("t2_lw", 8'h10, 3'b010, 3'd0, 32'hDEADBEEF);

    // Full queue: fifth store stalls one cycle while the head drains.
    st("t3_sw40", 8'h40, 3'b010, 32'hA0000000, 3'd0);
    st("t3_sw44", 8'h44, 3'b010, 32'hA0000001, 3'd1);
    st("t3_sw48", 8'h48, 3'b010, 32'hA0000002, 3'd2);
    st("t3_sw4c", 8'h4C, 3'b010, 32'hA0000003, 3'd3);
    st_full("t3_full", 8'h50, 3'b010, 32'hA0000004, 3'd4, 8'h40, 3'b010, 32'hA0000000);
    st("t3_accept", 8'h50, 3'b010, 32'hA0000004, 3'd3);
    drain("t3_dr44", 3'd4, 8'h44, 3'b010, 32'hA0000001);
    drain("t3_dr48", 3'd3, 8'h48, 3'b010, 32'hA0000002);
    drain("t3_dr4c", 3'd2, 8'h4C, 3'b010, 32'hA0000003);
    drain("t3_dr50", 3'd1, 8'h50, 3'b010, 32'hA0000004);
    idle("t3_idle", 3'd0);

    // Byte load fully covered by a pending word store.
    st("t4_sw", 8'h20, 3'b010, 32'h000080FF, 3'd0);
`ifdef STBUF_FWD_EN
    ld_fwd("t4_lb_fwd", 8'h20, 3'b000, 3'd1, 32'hFFFFFFFF);
    drain("t4_drain", 3'd1, 8'h20, 3'b010, 32'h000080FF);
`else
    ld_stall("t4_lb_stall", 8'h20, 3'b000, 3'd1, 8'h20, 3'b010, 32'h000080FF);
    ld_mem("t4_lb", 8'h20, 3'b000, 3'd0, 32'hFFFFFFFF);
`endif
    idle("t4_idle", 3'd0);

    // Partial coverage by the youngest entry: two stall cycles, merged result.
    st("t5_sw", 8'h20, 3'b010, 32'h11223344, 3'd0);
    st("t5_sb", 8'h21, 3'b000, 32'h00000080, 3'd1);
    ld_stall("t5_lw_s0", 8'h20, 3'b010, 3'd2, 8'h20, 3'b010, 32'h11223344);
    ld_stall("t5_lw_s1", 8'h20, 3'b010, 3'd1, 8'h21, 3'b000, 32'h00000080);
    ld_mem("t5_lw", 8'h20, 3'b010, 3'd0, 32'h11228044);

    // Non-overlapping load bypasses a pending store without draining it.
    st("t6_sw", 8'h40, 3'b010, 32'h00000055, 3'd0);
    ld_mem("t6_lw0", 8'h00, 3'b010, 3'd1, 32'h00040914);
    drain("t6_drain", 3'd1, 8'h40, 3'b010, 32'h00000055);
    idle("t6_idle", 3'd0);

    // Range edges: adjacent ranges do not overlap, the last byte does.
    st("t7_sw", 8'h60, 3'b010, 32'hCAFEF00D, 3'd0);
    ld_mem("t7_lh_above", 8'h64, 3'b001, 3'd1, 32'h00000000);
    ld_mem("t7_lhu_below", 8'h5E, 3'b101, 3'd1, 32'h00000000);
`ifdef STBUF_FWD_EN
    ld_fwd("t7_lbu_fwd", 8'h63, 3'b100, 3'd1, 32'h000000CA);
    ld_fwd("t7_lh_fwd", 8'h62, 3'b001, 3'd1, 32'hFFFFCAFE);
    drain("t7_drain", 3'd1, 8'h60, 3'b010, 32'hCAFEF00D);
`else
    ld_stall("t7_lbu_stall", 8'h63, 3'b100, 3'd1, 8'h60, 3'b010, 32'hCAFEF00D);
    ld_mem("t7_lbu", 8'h63, 3'b100, 3'd0, 32'h000000CA);
    ld_mem("t7_lh", 8'h62, 3'b001, 3'd0, 32'hFFFFCAFE);
`endif
    idle("t7_idle", 3'd0);

    @(posedge clk);
    @(posedge clk);
    #1;
    cmp("scoreboard", "pending", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-coalescing-free store buffer between the MEM pipeline stage and `DataMem` on its single shared address port. Stores are accepted in one cycle and queued, then retired in program order to `DataMem` on cycles when the port is otherwise free. Loads read `DataMem` combinationally unless they overlap a pending store. In that case the stage stalls and drains, or, when configured, forwards from the buffer.

## Interface
- `DEPTH`, 4: number of entries. Power of two, 2..16.
- `CW`, `$clog2(DEPTH+1)`: width of `count_o`.

- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset. Synchronous, active-high; one clock, synchronous active-high reset.
- `mem_read_i` in 1: MEM-stage load request. Never asserted together with `mem_write_i`.
- `mem_write_i` in 1: MEM-stage store request.
- `addr_i` in 8: byte address.
- `func3_i` in 3: access type, RV32 encoding. Loads: 000/001/010/100/101. Stores: 000/001/010.
- `wdata_i` in 32: store data, low bytes used for SB/SH.
- `rdata_o` out 32: load result, already sign- or zero-extended.
- `stall_o` out 1: MEM stage must hold the current request stable next cycle.
- `count_o` out CW: valid entries.
- `dm_MemRead`, `dm_MemWrite` out 1 each: `DataMem` controls.
- `dm_addr` out 8, `dm_func3` out 3, `dm_data_in` out 32: `DataMem` port.
- `dm_data_out` in 32: `DataMem` read data.

## Operation
- **Storage.** Circular FIFO of DEPTH entries `{addr[7:0], func3[1:0], data[31:0]}`, with head/tail pointers of `$clog2(DEPTH)` bits.
  - Pointers wrap modulo DEPTH.
  - Full/empty are derived from `count`.
- **Byte range.** An access covers bytes [addr, addr+size-1], where size is 1/2/4 from `func3[1:0]`.
  - Compare in 9 bits.
  - Accesses crossing byte 255 are illegal; behaviour is unspecified.
- **Overlap.** A load overlaps an entry when their byte ranges intersect.
- **Per-cycle decision**, in priority order:
  1. `rst`: head=tail=count=0. All outputs 0.
  2. **Load, no overlap with any valid entry.**
     - Drive `dm_MemRead`=1, `dm_addr`=`addr_i`, `dm_func3`=`func3_i`.
     - `rdata_o`=`dm_data_out`, `stall_o`=0.
     - No drain this cycle.
  3. **Load, overlapping.**
     - `stall_o`=1.
     - Drain the head: `dm_MemWrite`=1 with the entry's addr, `{1'b0,func3}` and data. Pop.
     - The load is re-evaluated next cycle.
  4. **Store, count<DEPTH.** Push `{addr_i, func3_i[1:0], wdata_i}` at tail. `stall_o`=0. No drain.
  5. **Store, count==DEPTH.** `stall_o`=1. Drain the head and do not push. The store is accepted next cycle.
  6. **Idle (no request).** If count>0, drain the head.
- **Port discipline.**
  - `dm_MemRead` and `dm_MemWrite` are never both 1.
  - When neither is active, `dm_addr`/`dm_func3`/`dm_data_in` are 0.
  - `rdata_o` is 0 on any cycle that is not a completed load.
- **Ordering.** Memory sees stores in program order. A load never observes stale data.

## Timing
- Store acceptance is 0 cycles when not full; the entry is visible to overlap checks from the next cycle.
- Store to memory: earliest on the first idle or stall cycle after acceptance. The write lands at that cycle's rising edge.
- Load with no hazard: same-cycle combinational result, 0 stall.
- Load with hazard: one stall cycle per drained entry, until no overlapping entry remains.
- `stall_o`, `rdata_o` and the `dm_*` outputs are combinational from state and the current request. `count_o` is registered.
- Reset mid-queue discards all pending stores. No write is issued in the reset cycle.

## Configuration
- **`STBUF_FWD_EN` defined:** a load is forwarded when both hold:
  - the youngest overlapping entry fully contains the load's byte range;
  - no younger entry overlaps.
- **Forwarded load behaviour:**
  - `rdata_o` is the selected bytes from that entry, extended per `func3_i`.
  - `stall_o`=0, no `DataMem` access, no drain.
  - Partial coverage still stalls and drains.
- **Undefined:** every overlapping load takes the stall/drain path. No forwarding datapath is built.

## Test plan
- Reset with a 3-entry queue → `count_o`=0, `stall_o`=0, no `dm_MemWrite` in the following idle cycles.
- SW 0x10=0xDEADBEEF, then 1 idle cycle → `dm_MemWrite`=1, `dm_addr`=0x10, `dm_func3`=010, `dm_data_in`=0xDEADBEEF; `count_o` goes 1→0.
- 5 back-to-back SW (DEPTH=4, addrs 0x40..0x50) → 5th sees `stall_o`=1 for one cycle while 0x40 drains; accepted next cycle; `count_o`=4.
- SW 0x20=0x000080FF, then LB 0x20:
  - with `STBUF_FWD_EN` → `rdata_o`=0xFFFFFFFF, no stall;
  - without → 1 stall cycle, then `rdata_o`=0xFFFFFFFF from memory.
- SW 0x20=0x11223344, SB 0x21=0x80, then LW 0x20 → stalls 2 cycles in both configurations, then `rdata_o`=0x11228044.
- Store pending at 0x40, then LW 0x00 on initial memory → no stall, `rdata_o`=0x00040914, `count_o` stays 1.
